a2d_sched: RTL

Scheduler that shares the single A2D SPI master among the four analog sources: left load cell, right load cell, steering pot and battery. On each `nxt` strobe it runs one conversion round. Each channel needs two SPI transfers: the first selects the channel, the second returns its result. Results land in per-channel registers consumed by the balance, steer and battery-monitor logic; `vld` pulses when a round completes.

---
 rtl/a2d_sched_pkg.sv | 15 +
 rtl/a2d_chan_xfer.sv | 67 ++++++
 rtl/a2d_sched.sv | 96 +++++++++
 3 files changed

// File: rtl/a2d_sched_pkg.sv
// a2d_sched_pkg: shared types, channel constants and command helper for the A2D scheduler.
package a2d_sched_pkg;
    typedef enum logic [2:0] {IDLE, SEL, WAIT_SEL, GAP, RD, WAIT_RD, NEXT} state_t;
    typedef enum logic [1:0] {LFT, RGHT, STEER, BATT} chan_t;
    localparam logic [2:0] CH_LFT = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT = 3'd6;
    function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction
    function automatic logic [2:0] ch_of(input chan_t c);
        return c == LFT ? CH_LFT : c == RGHT ? CH_RGHT : c == STEER ? CH_STEER : CH_BATT;
    endfunction
endpackage

// File: rtl/a2d_chan_xfer.sv
// a2d_chan_xfer: select-then-read SPI transfer pair for one channel, with per-transfer timeout.
module a2d_chan_xfer
    import a2d_sched_pkg::*;
#(
    parameter int TMO = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  ch,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] res,
    output logic        res_vld,
    output logic        tmo
);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TLIM = TW'(TMO - 1);
    state_t st;
    logic [TW-1:0] cnt;
    logic unused_hi;
    assign unused_hi = ^rd_data[15:12];
    assign res = rd_data[11:0];
    // the result is taken on the very edge that done arrives
    assign res_vld = st == WAIT_RD && done;
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            wrt <= 1'b0;
            cmd <= '0;
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            wrt <= 1'b0;
            tmo <= 1'b0;
            cnt <= cnt + 1'b1;
            unique case (st)
                IDLE: if (start) begin
                    st <= SEL;
                    wrt <= 1'b1;
                    cmd <= mk_cmd(ch);
                    cnt <= '0;
                end
                SEL: st <= WAIT_SEL;
                WAIT_SEL: if (done) st <= GAP;
                    else if (cnt == TLIM) begin
                        st <= IDLE;
                        tmo <= 1'b1;
                    end
                GAP: begin
                    st <= RD;
                    wrt <= 1'b1;
                    cnt <= '0;
                end
                RD: st <= WAIT_RD;
                WAIT_RD: if (done) st <= IDLE;
                    else if (cnt == TLIM) begin
                        st <= IDLE;
                        tmo <= 1'b1;
                    end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/a2d_sched.sv
// a2d_sched: round-robin scheduler sharing one A2D SPI master among load cells, steering pot and battery.
module a2d_sched
    import a2d_sched_pkg::*;
#(
    parameter int BATT_DIV = 8,
    parameter int TMO = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        vld,
    output logic        busy,
    output logic        err
);
    localparam int BW = BATT_DIV > 1 ? $clog2(BATT_DIV) : 1;
    localparam logic [BW-1:0] BMAX = BW'(BATT_DIV - 1);
    state_t st;
    chan_t idx, nidx;
    logic pend, last, start, res_vld, tmo;
    logic [BW-1:0] batt_cnt;
    logic [11:0] res;
    logic [2:0] ch;
    logic [11:0] res_q [4];
    // the battery is appended to the round only when its divider has wrapped
    always_comb begin
        nidx = chan_t'(idx + 2'd1);
        last = idx == BATT || (idx == STEER && batt_cnt != '0);
        start = (st == IDLE && (nxt || pend)) || (st == NEXT && !last);
        ch = ch_of(st == IDLE ? LFT : nidx);
    end
    a2d_chan_xfer #(.TMO(TMO)) u_xfer (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ch(ch),
        .done(done),
        .rd_data(rd_data),
        .wrt(wrt),
        .cmd(cmd),
        .res(res),
        .res_vld(res_vld),
        .tmo(tmo)
    );
    assign err = tmo;
    assign lft_ld = res_q[LFT];
    assign rght_ld = res_q[RGHT];
    assign steer_pot = res_q[STEER];
    assign batt = res_q[BATT];
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            idx <= LFT;
            pend <= 1'b0;
            busy <= 1'b0;
            vld <= 1'b0;
            batt_cnt <= '0;
            res_q <= '{default: '0};
        end else begin
            vld <= 1'b0;
            if (nxt && busy) pend <= 1'b1;
            unique case (st)
                IDLE: if (nxt || pend) begin
                    pend <= 1'b0;
                    idx <= LFT;
                    busy <= 1'b1;
                    st <= SEL;
                end
                SEL: if (res_vld) begin
                    res_q[idx] <= res;
                    st <= NEXT;
                end else if (tmo) begin
                    busy <= 1'b0;
                    st <= IDLE;
                end
                NEXT: if (last) begin
                    vld <= 1'b1;
                    batt_cnt <= batt_cnt == BMAX ? '0 : batt_cnt + 1'b1;
                    busy <= 1'b0;
                    st <= IDLE;
                end else begin
                    idx <= nidx;
                    st <= SEL;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
